// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types, constants and address helpers for inst_mem_pipelined
//
// Purpose: default fill word, controller state enum, the byte-address to
//          word-index decoder and the per-byte parity helper.
// Ports:   none (package).
package inst_mem_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic [31:0] idx;
        logic        ok;
    } word_index_t;

    // ok is set only for a word-aligned address inside [base, base + 4*depth).
    // idx is the full word offset; callers truncate it to their index width.
    function automatic word_index_t word_index(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [31:0] depth);
        word_index_t r;
        logic [31:0] off;
        off   = addr - base;
        r.idx = {2'b00, off[31:2]};
        r.ok  = (addr[1:0] == 2'b00) && (addr >= base) && (r.idx < depth);
        return r;
    endfunction

    // Even parity per byte: each bit makes its byte plus itself have an even count of ones.
    function automatic logic [3:0] byte_parity(input logic [31:0] w);
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - synchronous 1W/1R RAM with read-before-write
//
// Purpose: storage for the instruction words. The read register only loads
//          when re_i is high, so the output holds steady between reads.
// Ports:   clk     - clock
//          we_i    - write enable; waddr_i/wdata_i - write address/data
//          re_i    - read enable;  raddr_i - read address
//          rdata_o - registered read data (old contents on same-address write)
module inst_mem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_pipelined.sv
// rtl/inst_mem_pipelined.sv - synchronous instruction memory with fetch handshake and NOP sweep
//
// Purpose: DEPTH x 32-bit instruction store. After reset every word is swept
//          to NOP_WORD, then IF-stage fetches are served with a 1-cycle
//          valid/ready pipeline and a word-wide load port writes programs.
// Optional: INST_MEM_PARITY_EN adds per-byte even parity and the inj_par_err port.
// Ports:   clk, reset                          - clock, synchronous active-high reset
//          req_valid/req_ready/req_addr        - fetch request (byte PC)
//          resp_valid/resp_ready               - fetch response handshake
//          resp_instr/resp_fault               - fetched word, fault flag
//          ld_en/ld_addr/ld_data               - load-port write
//          init_done                           - NOP sweep finished
//          inj_par_err (parity build only)     - flip stored parity of byte 0 on load
module inst_mem_pipelined #(
    parameter int                 DEPTH     = 256,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [31:0]        NOP_WORD  = inst_mem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic              resp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              init_done
`ifdef INST_MEM_PARITY_EN
    ,
    input  logic              inj_par_err
`endif
);

    import inst_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
`ifdef INST_MEM_PARITY_EN
    localparam int MEM_W = 36;
`else
    localparam int MEM_W = 32;
`endif

    state_e           state_q, state_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             addr_fault_q, addr_fault_d;

    word_index_t      req_wi, ld_wi;
    logic             accept;
    logic             mem_we, mem_re;
    logic [IDX_W-1:0] mem_waddr, mem_raddr;
    logic [MEM_W-1:0] mem_wdata, mem_rdata;
    logic [MEM_W-1:0] sweep_word, load_word;
    logic             par_err;
    logic             unused_idx_bits;

    assign req_wi = word_index(32'(req_addr), 32'(BASE_ADDR), 32'(DEPTH));
    assign ld_wi  = word_index(32'(ld_addr),  32'(BASE_ADDR), 32'(DEPTH));
    assign unused_idx_bits = ^{req_wi.idx[31:IDX_W], ld_wi.idx[31:IDX_W]};

`ifdef INST_MEM_PARITY_EN
    assign sweep_word = {byte_parity(NOP_WORD), NOP_WORD};
    assign load_word  = {byte_parity(ld_data) ^ {3'b000, inj_par_err}, ld_data};
    assign par_err    = (mem_rdata[35:32] != byte_parity(mem_rdata[31:0]));
`else
    assign sweep_word = NOP_WORD;
    assign load_word  = ld_data;
    assign par_err    = 1'b0;
`endif

    // Single output register without skid: a new fetch is only taken when the
    // current response slot is empty or being drained this cycle.
    assign req_ready = (state_q == RUN) && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        addr_fault_d = addr_fault_q;
        mem_we       = 1'b0;
        mem_waddr    = ld_wi.idx[IDX_W-1:0];
        mem_wdata    = load_word;
        mem_re       = 1'b0;
        mem_raddr    = req_wi.idx[IDX_W-1:0];

        case (state_q)
            INIT: begin
                // cnt_q[IDX_W] set means every word has been written; the
                // extra cycle spent here is the hand-over to RUN.
                if (cnt_q[IDX_W]) begin
                    state_d = RUN;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q[IDX_W-1:0];
                    mem_wdata = sweep_word;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            RUN: begin
                mem_we = ld_en && ld_wi.ok;
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                end
                if (accept) begin
                    resp_valid_d = 1'b1;
                    addr_fault_d = !req_wi.ok;
                    mem_re       = req_wi.ok;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    inst_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // The RAM output register is not reset, so the response data is gated by
    // resp_valid; a faulted fetch never read the RAM and reports NOP_WORD.
    assign resp_valid = resp_valid_q;
    assign resp_instr = !resp_valid_q ? 32'h0 :
                        addr_fault_q  ? NOP_WORD : mem_rdata[31:0];
    assign resp_fault = resp_valid_q && (addr_fault_q || par_err);
    assign init_done  = (state_q == RUN);

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// tb/tb_inst_mem_pipelined.sv - self-checking bench for inst_mem_pipelined
module tb_inst_mem_pipelined;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_fault;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    inst_mem_pipelined #(
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .BASE_ADDR (BASE),
        .NOP_WORD  (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_fault (resp_fault),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .init_done  (init_done)
    );

    // Reference: an address is usable when word aligned and inside the window.
    function automatic bit ref_ok(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 == 0) && (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_ok(a) ? ref_mem[(a - BASE) / 4] : NOP;
    endfunction

    task automatic ref_sweep();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
        if (ref_ok(a)) ref_mem[(a - BASE) / 4] = d;
    endtask

    // Issues one fetch on an idle interface and returns what came back.
    task automatic do_fetch(input logic [31:0] a, output logic [31:0] instr,
                            output logic fault, output int lat);
        req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            step();
            lat++;
        end
        instr = resp_instr;
        fault = resp_fault;
        step();
    endtask

    // Holds reset, releases it, and returns the edge count until init_done.
    task automatic run_sweep(output int edges, output int early_ready);
        edges = 0;
        early_ready = 0;
        reset = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'hFFFF_FFFF;
        while (!init_done && edges < 300) begin
            step();
            edges++;
            if (!init_done && req_ready) early_ready++;
        end
        req_valid = 1'b0;
        ld_en = 1'b0;
        ref_sweep();
    endtask

    task automatic test_reset();
        int edges, early;
        logic [31:0] instr; logic fault; int lat;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if (resp_instr !== 32'h0) begin errors++; $display("FAIL reset_resp_instr got %h want 0", resp_instr); end
        checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_resp_fault got %b want 0", resp_fault); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
        run_sweep(edges, early);
        checks++; if (edges != DEPTH + 1) begin errors++; $display("FAIL init_latency got %0d want %0d", edges, DEPTH + 1); end
        checks++; if (early != 0) begin errors++; $display("FAIL init_req_ready got %0d early cycles want 0", early); end
        do_fetch(32'h0, instr, fault, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL fetch_latency got %0d want 1", lat); end
        checks++; if (instr !== NOP || fault !== 1'b0) begin errors++; $display("FAIL post_init_fetch got %h/%b want %h/0", instr, fault, NOP); end
    endtask

    task automatic test_reset_mid_sweep();
        int edges, early;
        // A stalled response must vanish on reset.
        req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_drops_resp got %b want 0", resp_valid); end
        reset = 1'b0;
        repeat (100) step();
        reset = 1'b1;
        step();
        run_sweep(edges, early);
        checks++; if (edges != DEPTH + 1) begin errors++; $display("FAIL restart_latency got %0d want %0d", edges, DEPTH + 1); end
        checks++; if (early != 0) begin errors++; $display("FAIL restart_req_ready got %0d early cycles want 0", early); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        prog[0] = 32'h0010_0093; prog[1] = 32'h0020_8093;
        prog[2] = 32'h0030_8093; prog[3] = 32'h0010_8113;
        for (int k = 0; k < 4; k++) do_load(32'(4 * k), prog[k]);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 32'(4 * k);
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", k, req_ready); end
            step();
            checks++;
            if (resp_valid !== 1'b1 || resp_instr !== prog[k] || resp_fault !== 1'b0) begin
                errors++; $display("FAIL b2b_resp[%0d] got %b/%h/%b want 1/%h/0", k, resp_valid, resp_instr, resp_fault, prog[k]);
            end
        end
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", resp_valid); end
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
        step();
        req_addr = 32'h8;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_instr !== ref_read(32'h4) || req_ready !== 1'b0) begin
                errors++; $display("FAIL stall[%0d] got v=%b d=%h rdy=%b want 1/%h/0", c, resp_valid, resp_instr, req_ready, ref_read(32'h4));
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== ref_read(32'h8)) begin
            errors++; $display("FAIL stall_next got %b/%h want 1/%h", resp_valid, resp_instr, ref_read(32'h8));
        end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", resp_valid); end
    endtask

    task automatic test_fault();
        logic [31:0] instr; logic fault; int lat;
        logic [31:0] bad [3];
        bad[0] = 32'h0000_0002; bad[1] = 32'h0000_0400; bad[2] = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            do_fetch(bad[k], instr, fault, lat);
            checks++;
            if (instr !== NOP || fault !== 1'b1 || lat != 1) begin
                errors++; $display("FAIL fault_fetch[%h] got %h/%b lat %0d want %h/1 lat 1", bad[k], instr, fault, lat, NOP);
            end
        end
        do_load(32'h0000_03FC, 32'h1234_5678);
        do_fetch(32'h0000_03FC, instr, fault, lat);
        checks++; if (instr !== 32'h1234_5678 || fault !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b want 12345678/0", instr, fault); end
        do_load(32'h0000_0400, 32'hCAFE_F00D);
        do_load(32'h0000_0002, 32'hBAAD_F00D);
        do_fetch(32'h0, instr, fault, lat);
        checks++; if (instr !== ref_read(32'h0) || fault !== 1'b0) begin errors++; $display("FAIL bad_load_dropped got %h/%b want %h/0", instr, fault, ref_read(32'h0)); end
    endtask

    task automatic test_read_before_write();
        logic [31:0] instr; logic fault; int lat;
        logic [31:0] old_word;
        old_word = ref_read(32'h8);
        ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
        step();
        ld_en = 1'b0; req_valid = 1'b0;
        ref_mem[2] = 32'hDEAD_BEEF;
        checks++; if (resp_instr !== old_word || resp_valid !== 1'b1) begin errors++; $display("FAIL rbw_old got %b/%h want 1/%h", resp_valid, resp_instr, old_word); end
        step();
        do_fetch(32'h8, instr, fault, lat);
        checks++; if (instr !== 32'hDEAD_BEEF || fault !== 1'b0) begin errors++; $display("FAIL rbw_new got %h/%b want deadbeef/0", instr, fault); end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7) return BASE + 4 * $urandom_range(0, DEPTH - 1);
        if (sel == 7) return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        if (sel == 8) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
        return $urandom;
    endfunction

    // Scoreboard: one response slot; a fetch sees memory before any same-cycle load.
    task automatic test_random();
        bit          m_valid = 1'b0;
        logic [31:0] m_instr = '0;
        bit          m_fault = 1'b0;
        bit          exp_ready, acc;
        int          bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr   = rand_addr();
            resp_ready = ($urandom_range(0, 2) != 0);
            ld_en      = ($urandom_range(0, 3) == 0);
            ld_addr    = rand_addr();
            ld_data    = $urandom;
            #1;
            exp_ready = !m_valid || resp_ready;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_ready[%0d] got %b want %b", cyc, req_ready, exp_ready);
            end
            acc = req_valid && exp_ready;
            if (m_valid && resp_ready) m_valid = 1'b0;
            if (acc) begin
                m_valid = 1'b1;
                m_fault = !ref_ok(req_addr);
                m_instr = ref_read(req_addr);
            end
            if (ld_en && ref_ok(ld_addr)) ref_mem[(ld_addr - BASE) / 4] = ld_data;
            step();
            checks++;
            if (resp_valid !== m_valid ||
                (m_valid && (resp_instr !== m_instr || resp_fault !== m_fault))) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_resp[%0d] got %b/%h/%b want %b/%h/%b", cyc,
                                       resp_valid, resp_instr, resp_fault, m_valid, m_instr, m_fault);
            end
        end
        req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_fault();
        test_read_before_write();
        test_random();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_pipelined.md
Name: inst_mem_pipelined

Overview:
Parametrised, synchronous instruction memory that replaces the byte-array, combinational-read instruction memory. It holds DEPTH words of 32-bit little-endian instructions and serves fetches from the IF stage over a valid/ready request/response handshake with 1-cycle read latency. After reset it runs a hardware sweep that fills every word with NOP. A word-wide load port lets the test bench or boot logic write programs.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..65536
ADDR_W, 32, width of byte address (PC)
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4
NOP_WORD, 32'h0000_0013, fill value (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  ADDR_W  byte address (PC) of fetch
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response when resp_valid && resp_ready
resp_instr  out  32  fetched instruction; {M[a+3],M[a+2],M[a+1],M[a]} byte order
resp_fault  out  1  request was misaligned or out of range
ld_en  in  1  load-port write strobe
ld_addr  in  ADDR_W  byte address of load write (word-aligned)
ld_data  in  32  word to write
init_done  out  1  high once the NOP sweep has completed

Behaviour:
- Reset (reset=1 at edge): state=INIT, sweep counter=0, req_ready=0, resp_valid=0, resp_instr=0, resp_fault=0, init_done=0. Reset mid-fetch drops the in-flight response; reset mid-sweep restarts the sweep at word 0.
- INIT: writes NOP_WORD to word[cnt] each cycle and increments cnt. Takes DEPTH cycles. On the cycle after cnt==DEPTH-1 is written: state=RUN, init_done=1. ld_en is ignored in INIT. Requests are refused (req_ready=0).
- RUN: req_ready = !resp_valid || resp_ready (single output register; no skid).
- Accepted request: on the next edge resp_valid=1 and resp_instr=word[idx], where idx=(req_addr-BASE_ADDR)>>2 truncated to log2(DEPTH) bits. Latency is exactly 1 cycle.
- resp_valid is held until the response is taken. resp_instr and resp_fault stay stable while resp_valid && !resp_ready.
- Response taken with no new request accepted: resp_valid drops next cycle. Response taken and a new request accepted in the same cycle: back-to-back, 1 fetch/cycle.
- Fault: req_addr[1:0]!=0, or req_addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH). Gives resp_fault=1 and resp_instr=NOP_WORD. No memory read is made. The fault goes through the same handshake and latency.
- Load port (RUN only): ld_en=1 writes ld_data to word[(ld_addr-BASE_ADDR)>>2]. A misaligned or out-of-range ld_addr is silently dropped. No handshake; one write/cycle.
- Load and fetch to the same word in the same cycle: the fetch returns the old data (read-before-write). The new data is visible to a fetch accepted on the next cycle.
- Address wrap: BASE_ADDR+4*DEPTH-4 is valid. The next word address faults; it does not wrap to word 0.

Optional Feature:
Macro INST_MEM_PARITY_EN.
- Defined: each word stores 4 extra even-parity bits, one per byte, computed on sweep and load writes. On read they are checked; any mismatch sets resp_fault=1 with the data returned unchanged. Adds input port inj_par_err (1 bit): when high during a load write, it inverts the stored parity bit of byte 0.
- Undefined: no parity storage, no inj_par_err port, and resp_fault reflects address faults only.

Decomposition:
- Package inst_mem_pkg holds: NOP_WORD constant, state enum {INIT, RUN}, and function word_index(addr, base, depth) returning index plus in-range/aligned flag.
- One sub-module, inst_mem_array: single-port-write/single-port-read synchronous RAM, DEPTH x (32 or 36) bits, read-before-write. It is inferable as BRAM.
- The FSM, handshake and fault logic live in the top module.

Test Plan:
- Reset released, DEPTH=256 -> init_done rises exactly 256+1 cycles later, and req_ready stays 0 until then. A fetch at 0x0 then returns 0x00000013, resp_fault=0.
- Load 0x00100093@0x0, 0x00208093@0x4, 0x00308093@0x8, 0x00108113@0xC, then 4 back-to-back fetches with resp_ready=1 -> the same 4 words arrive on 4 consecutive cycles.
- Fetch 0x4 with resp_ready=0 for 3 cycles -> resp_valid=1, resp_instr=0x00208093 stable, and req_ready=0 throughout. Raising resp_ready gives a handshake; the next request is accepted that same cycle.
- Fetches at 0x2 and at 0x400 (DEPTH=256) -> resp_fault=1, resp_instr=0x00000013. A load at 0x400 leaves the memory unchanged.
- Same-cycle ld_en to 0x8 with 0xDEADBEEF and fetch at 0x8 -> the response is 0x00308093; the following fetch returns 0xDEADBEEF.
- With INST_MEM_PARITY_EN: load at 0x10 with inj_par_err=1, then fetch 0x10 -> resp_fault=1 with the data returned intact. Also, assert reset mid-sweep at cycle 100 -> the sweep restarts and init_done arrives 257 cycles after release.
